// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// counter sizing and the controller state encoding.
package seq_divider_pkg;

  localparam int DEFAULT_DW = 5;
  localparam int DEFAULT_VW = 3;

  // Width of a counter that can hold DW-1, never narrower than one bit.
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DEFAULT_DW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int VW = DEFAULT_VW
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   rem_o,
  output logic          q_o
);

  logic [VW:0] shifted;
  logic        unused_rem_msb;

  // The partial remainder is always below the divisor after a step, except
  // for a zero divisor where its top bit is simply shifted out and lost.
  assign unused_rem_msb = rem_i[VW];
  assign shifted        = {rem_i[VW-1:0], bit_i};
  assign q_o            = (shifted >= {1'b0, divisor_i});
  assign rem_o          = q_o ? (shifted - {1'b0, divisor_i}) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per clock MSB first, start/ready/done handshake.
// Optional macro SEQ_DIVIDER_DBZ_EN: a zero divisor finishes in one cycle
// with dbz=1 instead of running all DW steps.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int VW = DEFAULT_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int            CW       = cnt_w(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;      // partial remainder
  logic [DW-1:0] dq_q, dq_d;        // dividend bits shift out, quotient bits shift in
  logic [VW-1:0] dvs_q, dvs_d;      // divisor captured at start
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_rem;
  logic          step_q;

  div_step #(.VW(VW)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Next-state and datapath: accept start when ready, iterate, publish the
  // result only on the last step so the visible outputs stay stable.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LAST;
          rem_d   = '0;
          dq_d    = dividend;
          dvs_d   = divisor;
`ifdef SEQ_DIVIDER_DBZ_EN
          if (divisor == '0) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[VW-1:0];
          end
`endif
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        dq_d  = {dq_q[DW-2:0], step_q};
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          dbz_d       = 1'b0;
          quotient_d  = {dq_q[DW-2:0], step_q};
          remainder_d = step_rem[VW-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any partial result and clears the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule
